// File: rtl/axi_lite_perf_pkg.sv
// Shared constants and types for the AXI4-Lite performance monitor:
// register map offsets, response codes and the latency-timer state.
package axi_lite_perf_pkg;

    // Global register byte offsets
    localparam int OFF_CTRL    = 'h00;
    localparam int OFF_OVF     = 'h04;
    localparam int OFF_NUM_CH  = 'h08;

    // Channel c lives at OFF_CH_BASE + CH_STRIDE*c
    localparam int OFF_CH_BASE = 'h10;
    localparam int CH_STRIDE   = 'h10;

    // Per-channel sub-offsets
    localparam int OFF_RD_CNT  = 'h0;
    localparam int OFF_WR_CNT  = 'h4;
    localparam int OFF_RD_LAT  = 'h8;
    localparam int OFF_WR_LAT  = 'hC;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lat_state_t;

endpackage

// File: rtl/axi_lite_perf_chan.sv
// One monitored AXI4-Lite link: saturating read/write handshake counters,
// oldest-outstanding latency timers with running maxima, sticky overflow.
module axi_lite_perf_chan
    import axi_lite_perf_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 core_clk,
    input  logic                 ext_rst,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 arvalid,
    input  logic                 arready,
    input  logic                 rvalid,
    input  logic                 rready,
    input  logic                 awvalid,
    input  logic                 awready,
    input  logic                 bvalid,
    input  logic                 bready,
    output logic [CNT_WIDTH-1:0] rd_cnt,
    output logic [CNT_WIDTH-1:0] wr_cnt,
    output logic [CNT_WIDTH-1:0] rd_lat_max,
    output logic [CNT_WIDTH-1:0] wr_lat_max,
    output logic                 ovf
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    // Index 0 is the read side, index 1 the write side; both behave identically.
    logic [1:0]                ev;
    logic [1:0]                done;
    logic [1:0][CNT_WIDTH-1:0] cnt, cnt_nxt;
    logic [1:0][CNT_WIDTH-1:0] tmr, tmr_nxt;
    logic [1:0][CNT_WIDTH-1:0] lat_max, max_nxt;
    lat_state_t                st [2];
    lat_state_t                st_nxt [2];
    logic                      ovf_nxt;

    assign ev   = {awvalid & awready, arvalid & arready};
    assign done = {bvalid & bready, rvalid & rready};

    always_comb begin
        ovf_nxt = ovf;
        for (int s = 0; s < 2; s++) begin
            cnt_nxt[s] = cnt[s];
            tmr_nxt[s] = tmr[s];
            max_nxt[s] = lat_max[s];
            st_nxt[s]  = st[s];
            if (enable) begin
                if (ev[s]) begin
                    if (cnt[s] == CNT_MAX) ovf_nxt = 1'b1;
                    else                   cnt_nxt[s] = cnt[s] + CNT_ONE;
                end
                case (st[s])
                    // A same-cycle request/response from idle is latency 0: no-op on the max.
                    IDLE: if (ev[s] && !done[s]) begin
                        st_nxt[s]  = BUSY;
                        tmr_nxt[s] = CNT_ONE;
                    end
                    BUSY: begin
                        if (done[s]) begin
                            if (tmr[s] > lat_max[s]) max_nxt[s] = tmr[s];
                            if (ev[s]) tmr_nxt[s] = CNT_ONE;
                            else       st_nxt[s]  = IDLE;
                        end else if (tmr[s] != CNT_MAX) begin
                            tmr_nxt[s] = tmr[s] + CNT_ONE;
                        end
                    end
                    default: st_nxt[s] = IDLE;
                endcase
            end
            if (clear) begin
                cnt_nxt[s] = '0;
                tmr_nxt[s] = '0;
                max_nxt[s] = '0;
                st_nxt[s]  = IDLE;
            end
        end
        if (clear) ovf_nxt = 1'b0;
    end

    always_ff @(posedge core_clk or posedge ext_rst) begin
        if (ext_rst) begin
            cnt     <= '0;
            tmr     <= '0;
            lat_max <= '0;
            st      <= '{default: IDLE};
            ovf     <= 1'b0;
        end else begin
            cnt     <= cnt_nxt;
            tmr     <= tmr_nxt;
            lat_max <= max_nxt;
            st      <= st_nxt;
            ovf     <= ovf_nxt;
        end
    end

    assign rd_cnt     = cnt[0];
    assign wr_cnt     = cnt[1];
    assign rd_lat_max = lat_max[0];
    assign wr_lat_max = lat_max[1];

endmodule

// File: rtl/axi_lite_perf_monitor.sv
// Non-intrusive statistics monitor for NUM_CH AXI4-Lite links, with its own
// AXI4-Lite register slave for reading and clearing the statistics.
module axi_lite_perf_monitor
    import axi_lite_perf_pkg::*;
#(
    parameter int NUM_CH     = 4,
    parameter int CNT_WIDTH  = 16,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  core_clk,
    input  logic                  ext_rst,
    input  logic [NUM_CH-1:0]     mon_arvalid,
    input  logic [NUM_CH-1:0]     mon_arready,
    input  logic [NUM_CH-1:0]     mon_rvalid,
    input  logic [NUM_CH-1:0]     mon_rready,
    input  logic [NUM_CH-1:0]     mon_awvalid,
    input  logic [NUM_CH-1:0]     mon_awready,
    input  logic [NUM_CH-1:0]     mon_bvalid,
    input  logic [NUM_CH-1:0]     mon_bready,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    input  logic [31:0]           s_wdata,
    input  logic [3:0]            s_wstrb,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    output logic [1:0]            s_bresp,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    output logic                  s_rvalid,
    input  logic                  s_rready,
    output logic [31:0]           s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  ovf_any
);

    localparam int BW = ADDR_WIDTH - 4;

    logic [NUM_CH-1:0][CNT_WIDTH-1:0] rd_cnt, wr_cnt, rd_lat_max, wr_lat_max;
    logic [NUM_CH-1:0]                ovf;
    logic                             ctrl_en;
    logic                             clear_q;
    logic                             wr_rdy, ar_rdy;
    logic                             wr_hs, rd_hs;
    logic                             aw_hit, ar_hit;
    logic [31:0]                      rd_word;
    logic                             unused_wbits;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        axi_lite_perf_chan #(.CNT_WIDTH(CNT_WIDTH)) u_chan (
            .core_clk   (core_clk),
            .ext_rst    (ext_rst),
            .enable     (ctrl_en),
            .clear      (clear_q),
            .arvalid    (mon_arvalid[c]),
            .arready    (mon_arready[c]),
            .rvalid     (mon_rvalid[c]),
            .rready     (mon_rready[c]),
            .awvalid    (mon_awvalid[c]),
            .awready    (mon_awready[c]),
            .bvalid     (mon_bvalid[c]),
            .bready     (mon_bready[c]),
            .rd_cnt     (rd_cnt[c]),
            .wr_cnt     (wr_cnt[c]),
            .rd_lat_max (rd_lat_max[c]),
            .wr_lat_max (wr_lat_max[c]),
            .ovf        (ovf[c])
        );
    end

    // Block 0 holds the global words; block 1+c holds channel c.
    function automatic logic addr_hit(input logic [ADDR_WIDTH-1:0] a);
        logic [BW-1:0] blk;
        logic [3:0]    off;
        blk = a[ADDR_WIDTH-1:4];
        off = a[3:0];
        if (off[1:0] != 2'b00) return 1'b0;
        if (blk == '0)
            return (off == 4'(OFF_CTRL)) || (off == 4'(OFF_OVF)) || (off == 4'(OFF_NUM_CH));
        return int'(blk) <= NUM_CH;
    endfunction

    assign aw_hit = addr_hit(s_awaddr);
    assign ar_hit = addr_hit(s_araddr);

    always_comb begin
        rd_word = '0;
        if (s_araddr[ADDR_WIDTH-1:4] == '0) begin
            case (s_araddr[3:0])
                4'(OFF_CTRL):   rd_word = {31'b0, ctrl_en};
                4'(OFF_OVF):    rd_word = 32'(ovf);
                4'(OFF_NUM_CH): rd_word = 32'(NUM_CH);
                default:        rd_word = '0;
            endcase
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (int'(s_araddr[ADDR_WIDTH-1:4]) == c + OFF_CH_BASE / CH_STRIDE) begin
                    case (s_araddr[3:0])
                        4'(OFF_RD_CNT): rd_word = 32'(rd_cnt[c]);
                        4'(OFF_WR_CNT): rd_word = 32'(wr_cnt[c]);
                        4'(OFF_RD_LAT): rd_word = 32'(rd_lat_max[c]);
                        4'(OFF_WR_LAT): rd_word = 32'(wr_lat_max[c]);
                        default:        rd_word = '0;
                    endcase
                end
            end
        end
    end

    assign wr_hs = wr_rdy & s_awvalid & s_wvalid;
    assign rd_hs = ar_rdy & s_arvalid;

    // Ready flops toggle off after one cycle so each handshake is a single pulse.
    always_ff @(posedge core_clk or posedge ext_rst) begin
        if (ext_rst) begin
            wr_rdy   <= 1'b0;
            s_bvalid <= 1'b0;
            s_bresp  <= RESP_OKAY;
            ctrl_en  <= 1'b1;
            clear_q  <= 1'b0;
        end else begin
            clear_q <= 1'b0;
            wr_rdy  <= !wr_rdy && !s_bvalid && s_awvalid && s_wvalid;
            if (wr_hs) begin
                s_bvalid <= 1'b1;
                s_bresp  <= aw_hit ? RESP_OKAY : RESP_SLVERR;
                if (s_awaddr == ADDR_WIDTH'(OFF_CTRL) && s_wstrb[0]) begin
                    ctrl_en <= s_wdata[0];
                    clear_q <= s_wdata[1];
                end
            end else if (s_bvalid && s_bready) begin
                s_bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge core_clk or posedge ext_rst) begin
        if (ext_rst) begin
            ar_rdy   <= 1'b0;
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else begin
            ar_rdy <= !ar_rdy && !s_rvalid && s_arvalid;
            if (rd_hs) begin
                s_rvalid <= 1'b1;
                s_rdata  <= ar_hit ? rd_word : 32'h0;
                s_rresp  <= ar_hit ? RESP_OKAY : RESP_SLVERR;
            end else if (s_rvalid && s_rready) begin
                s_rvalid <= 1'b0;
            end
        end
    end

    assign s_awready    = wr_rdy;
    assign s_wready     = wr_rdy;
    assign s_arready    = ar_rdy;
    assign ovf_any      = |ovf;
    assign unused_wbits = ^{s_wdata[31:2], s_wstrb[3:1]};

endmodule

// File: tb/tb_axi_lite_perf_monitor.sv
// Bench for axi_lite_perf_monitor: directed and random link traffic scored
// against a timestamp-based reference model, register slave protocol checks.
module tb_axi_lite_perf_monitor;
    import axi_lite_perf_pkg::*;

    localparam int NCH  = 4;
    localparam int CW   = 8;
    localparam int AW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    logic           core_clk = 1'b0;
    logic           ext_rst;
    logic [NCH-1:0] mon_arvalid, mon_arready, mon_rvalid, mon_rready;
    logic [NCH-1:0] mon_awvalid, mon_awready, mon_bvalid, mon_bready;
    logic           s_awvalid, s_awready, s_wvalid, s_wready;
    logic [AW-1:0]  s_awaddr, s_araddr;
    logic [31:0]    s_wdata, s_rdata;
    logic [3:0]     s_wstrb;
    logic           s_bvalid, s_bready, s_arvalid, s_arready, s_rvalid, s_rready;
    logic [1:0]     s_bresp, s_rresp;
    logic           ovf_any;

    axi_lite_perf_monitor #(.NUM_CH(NCH), .CNT_WIDTH(CW), .ADDR_WIDTH(AW)) dut (
        .core_clk(core_clk), .ext_rst(ext_rst),
        .mon_arvalid(mon_arvalid), .mon_arready(mon_arready),
        .mon_rvalid(mon_rvalid), .mon_rready(mon_rready),
        .mon_awvalid(mon_awvalid), .mon_awready(mon_awready),
        .mon_bvalid(mon_bvalid), .mon_bready(mon_bready),
        .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr),
        .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
        .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr),
        .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
        .ovf_any(ovf_any)
    );

    always #5 core_clk = ~core_clk;

    int cyc = 0;
    always @(posedge core_clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Reference model: counts, maxima and the start time of the oldest outstanding request.
    bit             m_en;
    int             m_cnt   [2][NCH];
    int             m_max   [2][NCH];
    bit             m_busy  [2][NCH];
    int             m_start [2][NCH];
    bit [NCH-1:0]   m_ovf;

    function automatic void m_clear();
        for (int s = 0; s < 2; s++)
            for (int c = 0; c < NCH; c++) begin
                m_cnt[s][c] = 0; m_max[s][c] = 0; m_busy[s][c] = 0; m_start[s][c] = 0;
            end
        m_ovf = '0;
    endfunction

    function automatic void m_side(int s, int c, bit ev, bit done, int now);
        int lat;
        if (!m_en) return;
        if (ev) begin
            if (m_cnt[s][c] == CMAX) m_ovf[c] = 1'b1;
            else                     m_cnt[s][c]++;
        end
        if (m_busy[s][c]) begin
            if (done) begin
                lat = now - m_start[s][c];
                if (lat > CMAX) lat = CMAX;
                if (lat > m_max[s][c]) m_max[s][c] = lat;
                if (ev) m_start[s][c] = now;
                else    m_busy[s][c] = 1'b0;
            end
        end else if (ev && !done) begin
            m_busy[s][c]  = 1'b1;
            m_start[s][c] = now;
        end
    endfunction

    task automatic mon_cycle(input logic [NCH-1:0] arv, arr, rv, rr, awv, awr, bv, br);
        @(negedge core_clk);
        mon_arvalid = arv; mon_arready = arr; mon_rvalid = rv; mon_rready = rr;
        mon_awvalid = awv; mon_awready = awr; mon_bvalid = bv; mon_bready = br;
        for (int c = 0; c < NCH; c++) begin
            m_side(0, c, arv[c] & arr[c], rv[c] & rr[c], cyc);
            m_side(1, c, awv[c] & awr[c], bv[c] & br[c], cyc);
        end
    endtask

    task automatic mon_idle(input int n);
        for (int i = 0; i < n; i++) mon_cycle('0, '0, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic rd_ev(input logic [NCH-1:0] m);
        mon_cycle(m, m, '0, '0, '0, '0, '0, '0);
    endtask

    task automatic rd_done(input logic [NCH-1:0] m);
        mon_cycle('0, '0, m, m, '0, '0, '0, '0);
    endtask

    task automatic reg_read(input logic [AW-1:0] a, output logic [31:0] d, output logic [1:0] r);
        int n;
        @(negedge core_clk);
        s_araddr = a; s_arvalid = 1'b1; n = 0;
        while (!s_arready && n < 20) begin @(negedge core_clk); n++; end
        if (!s_arready) chk("ar_timeout", 32'd0, 32'd1);
        @(negedge core_clk);
        s_arvalid = 1'b0; n = 0;
        while (!s_rvalid && n < 20) begin @(negedge core_clk); n++; end
        if (!s_rvalid) chk("r_timeout", 32'd0, 32'd1);
        d = s_rdata; r = s_rresp; s_rready = 1'b1;
        @(negedge core_clk);
        s_rready = 1'b0;
    endtask

    task automatic reg_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] strb,
                             output logic [1:0] r);
        int n;
        @(negedge core_clk);
        s_awaddr = a; s_wdata = d; s_wstrb = strb; s_awvalid = 1'b1; s_wvalid = 1'b1; n = 0;
        while (!(s_awready && s_wready) && n < 20) begin @(negedge core_clk); n++; end
        if (!(s_awready && s_wready)) chk("aw_timeout", 32'd0, 32'd1);
        @(negedge core_clk);
        s_awvalid = 1'b0; s_wvalid = 1'b0; n = 0;
        while (!s_bvalid && n < 20) begin @(negedge core_clk); n++; end
        if (!s_bvalid) chk("b_timeout", 32'd0, 32'd1);
        r = s_bresp; s_bready = 1'b1;
        @(negedge core_clk);
        s_bready = 1'b0;
        if (a == 0 && strb[0]) begin
            m_en = d[0];
            if (d[1]) m_clear();
        end
    endtask

    task automatic expect_rd(input string tag, input logic [AW-1:0] a, input logic [31:0] exp,
                             input logic [1:0] resp);
        logic [31:0] d;
        logic [1:0]  r;
        reg_read(a, d, r);
        chk(tag, d, exp);
        chk({tag, "_resp"}, 32'(r), 32'(resp));
    endtask

    task automatic check_all(input string tag);
        logic [31:0] d;
        logic [1:0]  r;
        for (int c = 0; c < NCH; c++) begin
            reg_read(8'(16 + 16 * c), d, r); chk($sformatf("%s_rdcnt%0d", tag, c), d, 32'(m_cnt[0][c]));
            reg_read(8'(20 + 16 * c), d, r); chk($sformatf("%s_wrcnt%0d", tag, c), d, 32'(m_cnt[1][c]));
            reg_read(8'(24 + 16 * c), d, r); chk($sformatf("%s_rdlat%0d", tag, c), d, 32'(m_max[0][c]));
            reg_read(8'(28 + 16 * c), d, r); chk($sformatf("%s_wrlat%0d", tag, c), d, 32'(m_max[1][c]));
        end
        reg_read(8'h04, d, r);
        chk({tag, "_ovf"}, d, 32'(m_ovf));
        chk({tag, "_ovf_any"}, 32'(ovf_any), 32'(|m_ovf));
    endtask

    initial begin
        logic [1:0]  r;
        logic [31:0] d;
        logic [NCH-1:0] v [8];

        ext_rst = 1'b1;
        {mon_arvalid, mon_arready, mon_rvalid, mon_rready} = '0;
        {mon_awvalid, mon_awready, mon_bvalid, mon_bready} = '0;
        s_awvalid = 0; s_wvalid = 0; s_bready = 0; s_arvalid = 0; s_rready = 0;
        s_awaddr = '0; s_araddr = '0; s_wdata = '0; s_wstrb = '0;
        m_en = 1'b1; m_clear();
        repeat (3) @(negedge core_clk);
        chk("rst_arready", 32'(s_arready), 0);
        chk("rst_rvalid", 32'(s_rvalid), 0);
        chk("rst_bvalid", 32'(s_bvalid), 0);
        chk("rst_ovf_any", 32'(ovf_any), 0);
        ext_rst = 1'b0;

        expect_rd("ctrl_rst", 8'h00, 32'h1, RESP_OKAY);
        expect_rd("ovf_rst", 8'h04, 32'h0, RESP_OKAY);
        expect_rd("numch", 8'h08, NCH, RESP_OKAY);
        for (int a = 'h10; a <= 'h4C; a += 4)
            expect_rd($sformatf("zero_%0h", a), 8'(a), 32'h0, RESP_OKAY);

        // Channel 1: three reads, each answered 5 cycles after the request
        for (int k = 0; k < 3; k++) begin
            rd_ev(4'b0010); mon_idle(4); rd_done(4'b0010);
        end
        mon_idle(1);
        expect_rd("ch1_rdcnt", 8'h20, 3, RESP_OKAY);
        expect_rd("ch1_rdlat", 8'h28, 5, RESP_OKAY);
        expect_rd("ch0_rdcnt_u", 8'h10, 0, RESP_OKAY);
        expect_rd("ch2_rdcnt_u", 8'h30, 0, RESP_OKAY);
        check_all("ch1");

        // Channel 2: saturate the write counter
        for (int k = 0; k < 256; k++) mon_cycle('0, '0, '0, '0, 4'b0100, 4'b0100, '0, '0);
        mon_idle(1);
        expect_rd("ch2_wrsat", 8'h34, 32'hFF, RESP_OKAY);
        expect_rd("ovf_set", 8'h04, 32'h4, RESP_OKAY);
        chk("ovf_any_set", 32'(ovf_any), 1);
        reg_write(8'h00, 32'h3, 4'hF, r);
        chk("clr_bresp", 32'(r), 32'(RESP_OKAY));
        expect_rd("ch2_wrclr", 8'h34, 0, RESP_OKAY);
        expect_rd("ovf_clr", 8'h04, 0, RESP_OKAY);
        expect_rd("ctrl_clr", 8'h00, 1, RESP_OKAY);
        chk("ovf_any_clr", 32'(ovf_any), 0);

        // Channel 0: back-to-back requests, oldest one is timed
        rd_ev(4'b0001); rd_ev(4'b0001); mon_idle(2); rd_done(4'b0001); mon_idle(1);
        expect_rd("ch0_rdcnt", 8'h10, 2, RESP_OKAY);
        expect_rd("ch0_rdlat", 8'h18, 4, RESP_OKAY);
        mon_cycle(4'b0001, 4'b0001, 4'b0001, 4'b0001, '0, '0, '0, '0); mon_idle(1);
        expect_rd("ch0_rdlat_z", 8'h18, 4, RESP_OKAY);
        expect_rd("ch0_rdcnt3", 8'h10, 3, RESP_OKAY);

        // Channel 3: completion and new request in one cycle restarts the timer
        rd_ev(4'b1000); mon_idle(2);
        mon_cycle(4'b1000, 4'b1000, 4'b1000, 4'b1000, '0, '0, '0, '0);
        mon_idle(5); rd_done(4'b1000); mon_idle(1);
        expect_rd("ch3_restart", 8'h48, 6, RESP_OKAY);

        // Disabled: writes on channel 3 are not counted
        reg_write(8'h00, 32'h0, 4'hF, r);
        for (int k = 0; k < 10; k++) begin
            mon_cycle('0, '0, '0, '0, 4'b1000, 4'b1000, '0, '0);
            mon_idle(1);
            mon_cycle('0, '0, '0, '0, '0, '0, 4'b1000, 4'b1000);
        end
        mon_idle(1);
        expect_rd("dis_wrcnt", 8'h44, 0, RESP_OKAY);
        expect_rd("dis_wrlat", 8'h4C, 0, RESP_OKAY);
        reg_write(8'h00, 32'h1, 4'hF, r);
        expect_rd("ctrl_en", 8'h00, 1, RESP_OKAY);
        reg_write(8'h00, 32'h0, 4'h0, r);
        expect_rd("ctrl_nostrb", 8'h00, 1, RESP_OKAY);

        // Random traffic on all channels, two densities
        for (int round = 0; round < 2; round++) begin
            for (int k = 0; k < 150; k++) begin
                for (int j = 0; j < 8; j++)
                    v[j] = NCH'(round == 0 ? $urandom_range(0, 15) : ($urandom_range(0, 15) & $urandom_range(0, 15)));
                mon_cycle(v[0], v[1], v[2], v[3], v[4], v[5], v[6], v[7]);
            end
            mon_idle(1);
            check_all($sformatf("rnd%0d", round));
        end

        // Register slave error paths
        expect_rd("slverr_ch4", 8'h50, 0, RESP_SLVERR);
        expect_rd("slverr_0c", 8'h0C, 0, RESP_SLVERR);
        reg_write(8'h50, 32'h3, 4'hF, r);
        chk("slverr_wr", 32'(r), 32'(RESP_SLVERR));
        reg_write(8'h04, 32'hF, 4'hF, r);
        chk("ro_wr_resp", 32'(r), 32'(RESP_OKAY));
        expect_rd("ro_ovf", 8'h04, 32'(m_ovf), RESP_OKAY);

        // Hold rready low with read data pending, then reset mid-transaction
        @(negedge core_clk);
        s_araddr = 8'h08; s_arvalid = 1'b1;
        for (int n = 0; n < 20 && !s_arready; n++) @(negedge core_clk);
        @(negedge core_clk);
        s_arvalid = 1'b0;
        for (int n = 0; n < 20 && !s_rvalid; n++) @(negedge core_clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge core_clk);
            chk($sformatf("hold_rvalid%0d", k), 32'(s_rvalid), 1);
            chk($sformatf("hold_rdata%0d", k), s_rdata, NCH);
        end
        ext_rst = 1'b1;
        #1;
        chk("mid_rst_rvalid", 32'(s_rvalid), 0);
        chk("mid_rst_rdata", s_rdata, 0);
        chk("mid_rst_ovf_any", 32'(ovf_any), 0);
        m_en = 1'b1; m_clear();
        @(negedge core_clk);
        ext_rst = 1'b0;
        expect_rd("post_rst_ctrl", 8'h00, 1, RESP_OKAY);
        expect_rd("post_rst_cnt", 8'h10, 0, RESP_OKAY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
